sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the successor to our fixed 32-bit sync FIFO.
- Generalises data width and depth.
- Adds programmable almost-full/almost-empty flags, an occupancy count, overflow/underflow error pulses and a synchronous flush.
- Offers a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in a single clock domain.

Parameters:
DATA_WIDTH, 32, width of datain/dataout.
DEPTH, 16, number of entries; power of two, >= 2.
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH; range 1..DEPTH.
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; range 0..DEPTH-1.
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
we  in  1  write request.
re  in  1  read request.
flush  in  1  synchronous clear of contents.
datain  in  DATA_WIDTH  write data.
dataout  out  DATA_WIDTH  read data.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
count  out  AW+1  occupancy 0..DEPTH, where AW = $clog2(DEPTH).
overflow  out  1  one-cycle pulse: write rejected.
underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - wr_ptr, rd_ptr and count = 0.
  - dataout = 0; empty = 1; almost_empty = 1.
  - full, almost_full, overflow and underflow = 0.
  - Storage contents are not reset.
- Pointers are AW bits and wrap modulo DEPTH. count is a registered up/down counter.
- All flags are combinational decodes of the registered count, so they are glitch-free relative to clk.
- Accept rules, evaluated per cycle on pre-edge state:
  - wr_ok = we & (!full | rd_ok).
  - rd_ok = re & !empty.
- Simultaneous we&re:
  - When full: both accepted; count unchanged; the read frees a slot for the write.
  - When empty: write accepted, read rejected; underflow pulses; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- overflow = registered (we & full & !re); it pulses the cycle after the rejected write. No state change occurs.
- underflow = registered (re & empty); it pulses the cycle after the rejected read. No state change occurs.
- Standard mode (FWFT=0):
  - On rd_ok, dataout <= mem[rd_ptr] at that edge. Latency is 1 cycle from re sampled high.
  - dataout holds its value when there is no accepted read.
- FWFT mode (FWFT=1):
  - dataout = mem[rd_ptr] combinationally whenever !empty.
  - re acknowledges/pops the current word.
  - dataout = 0 while empty.
  - A word written into an empty FIFO appears on dataout the cycle after the write edge.
- flush:
  - Highest priority after reset; we/re in the same cycle are ignored.
  - Pointers and count clear to 0; dataout clears to 0.
  - No overflow/underflow pulse is raised for that cycle.
- Write data is stored at mem[wr_ptr] on wr_ok, then wr_ptr increments.
- Reset mid-operation discards all contents immediately. The first post-reset write occupies entry 0.

Test Plan:
1. DEPTH=16, FWFT=0: write 0x11..0x14 (4 writes) then 4 reads.
   -> dataout = 0x11,0x12,0x13,0x14, each one cycle after its re.
   -> count 4 -> 0; empty returns to 1.
2. Fill 16 words (AF_THRESH=14).
   -> almost_full rises at count=14; full rises at 16.
   -> A 17th write gives overflow=1 for one cycle; count stays 16.
   -> Subsequent reads return the 16 words in order with no corruption.
3. At full, assert we=1, re=1 with datain=0xAA for one cycle.
   -> count stays 16; no overflow.
   -> 0xAA is read out last after 16 pops.
4. On an empty FIFO, assert re alone -> underflow pulse; count 0.
   -> Then assert we&re with 0x55 -> underflow pulse; count=1; the next read returns 0x55.
5. FWFT=1: write 0x5A into an empty FIFO.
   -> dataout = 0x5A the cycle after the write with no re.
   -> re pops it; dataout -> 0; empty=1.
6. Write 6 words, then assert flush with we=1.
   -> count=0, empty=1, dataout=0; the write is ignored.
   -> Pull rst low mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses, synchronous
// flush and a choice of registered or first-word-fall-through read data.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    re,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   datain,
    output logic [DATA_WIDTH-1:0]   dataout,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_COUNT   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_COUNT   = (AW+1)'(AE_THRESH);

    // Storage is deliberately left without reset so it maps onto RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_ok, rd_ok;

    // Flags decode only the registered count, so they never glitch mid-cycle.
    assign full         = (count_reg == FULL_COUNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_COUNT);
    assign almost_empty = (count_reg <= AE_COUNT);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Accept decisions and next-state; flush masks both requests outright.
    always_comb begin
        rd_ok          = re & ~empty & ~flush;
        // A read on a full FIFO frees the slot the write needs.
        wr_ok          = we & (~full | rd_ok) & ~flush;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = we & full & ~re & ~flush;
        underflow_next = re & empty & ~flush;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (rd_ok) rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_next = count_reg + (AW+1)'(1);
                2'b01:   count_next = count_reg - (AW+1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state register; reset asserts immediately, releases on the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // RAM write port: accepted writes land at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= datain;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is presented directly; zero while nothing is stored.
            assign dataout = empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dataout_reg;

            // Registered read port: loads on an accepted read, holds otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dataout_reg <= '0;
                end else if (flush) begin
                    dataout_reg <= '0;
                end else if (rd_ok) begin
                    dataout_reg <= mem[rd_ptr_reg];
                end
            end

            assign dataout = dataout_reg;
        end
    endgenerate

endmodule
